mvu_dma_src_icb_master: RTL and testbench
=========================================

Name: mvu_dma_src_icb_master

Overview:
Upstream read engine for the MVU DMA core's source port. It converts the core's simple request/acknowledge word reads (source_address/source_valid → source_ready/source_data) into E203 ICB master read transactions toward system memory. It holds at most one outstanding ICB read. A one-word sequential prefetch buffer hides ICB latency on linear transfers.

Parameters:
ADDR_W, 32, address width (must equal `E203_ADDR_SIZE)
DATA_W, 32, data width (must equal `E203_XLEN)
PREFETCH_EN, 1, 1 = speculative read of next word after each served word; 0 = disabled

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
source_address  in  ADDR_W  word address requested by DMA core
source_valid  in  1  request; held with stable address until source_ready
source_ready  out  1  one-cycle acknowledge; source_data valid this cycle
source_data  out  DATA_W  read word
flush_i  in  1  invalidate prefetch buffer (tied to DMA start)
m_icb_cmd_valid  out  1  ICB command valid
m_icb_cmd_ready  in  1  ICB command accepted
m_icb_cmd_addr  out  ADDR_W  word-aligned read address
m_icb_cmd_read  out  1  constant 1
m_icb_cmd_wdata  out  DATA_W  constant 0
m_icb_cmd_wmask  out  DATA_W/8  constant 0
m_icb_rsp_valid  in  1  ICB response valid
m_icb_rsp_ready  out  1  ICB response accept
m_icb_rsp_err  in  1  ICB response error
m_icb_rsp_rdata  in  DATA_W  ICB response data
err_o  out  1  sticky demand-read error flag
err_addr_o  out  ADDR_W  address of the first demand-read error
err_clr_i  in  1  clears err_o and err_addr_o

Behaviour:
- Reset: synchronous, rst_n low at a clock edge:
  - All outputs go to 0, except m_icb_cmd_read, which is 1.
  - State goes to IDLE; pf_valid and pf_pending go to 0.
  - Any ICB transaction in flight is abandoned. The bus shares this reset.
- Address handling: source_address[1:0] are ignored; m_icb_cmd_addr = {addr[ADDR_W-1:2], 2'b00}.
- States:
  - IDLE
  - D_CMD / D_RSP: demand read
  - P_CMD / P_RSP: prefetch
  - ACK
- IDLE, source_valid sampled high:
  - If pf_valid and pf_addr matches the aligned source_address: go to ACK with source_data = pf_data. source_ready is asserted in the next cycle (hit latency 1).
  - Otherwise: go to D_CMD. pf_valid is cleared.
- D_CMD: m_icb_cmd_valid = 1 with a stable address until m_icb_cmd_ready; then go to D_RSP.
- D_RSP: m_icb_rsp_ready = 1. On m_icb_rsp_valid, register the data and go to ACK.
  - Minimum miss latency: source_valid at T, cmd at T+1, rsp at T+2, source_ready at T+3.
- ACK:
  - source_ready = 1 for exactly one cycle; source_data is registered.
  - Next state is P_CMD for address A+4 if PREFETCH_EN=1, the demand read did not error, and A != 0xFFFF_FFFC (no wrap prefetch). Otherwise the next state is IDLE.
- P_CMD / P_RSP: same handshake as D_CMD / D_RSP.
  - On response without error: pf_addr = A+4, pf_data = rdata, pf_valid = 1.
  - On response with error: pf_valid = 0 and err_o is not set (the read was speculative).
- Request during prefetch: a source_valid arriving in P_CMD/P_RSP waits. The prefetch always completes; then the IDLE hit/miss rule applies. The ICB command is never withdrawn once valid.
- Demand error:
  - source_ready still pulses, with source_data = 0.
  - err_o is set. err_addr_o captures the address only if err_o was 0.
  - err_clr_i clears both outputs. A new error in the same cycle as err_clr_i wins: err_o stays 1 and err_addr_o is reloaded.
- flush_i:
  - Clears pf_valid immediately.
  - If asserted during P_CMD/P_RSP, the pending prefetch response is discarded when it arrives.
  - Demand reads are unaffected.
- source_valid dropped before source_ready (protocol violation by the core): the outstanding ICB read completes. The data is discarded, no ACK is issued, and the FSM returns to IDLE.
- m_icb_rsp_ready is 1 only in D_RSP/P_RSP. A response arriving in any other state cannot occur, given a single outstanding transaction.

Decomposition:
- Shared package mvu_dma_pkg:
  - FSM state encoding.
  - WORD_BYTES = 4.
  - Error-flag field positions reused by the register block's status word.
- Widths come from e203_defines.v.
- One sub-module: mvu_dma_src_pfbuf, which holds the pf_addr/pf_data/pf_valid/pf_pending registers and the match comparator, plus flush and discard logic.

Test Plan:
- Single miss: request 0x8000_0010, cmd_ready immediate, rsp 0xDEADBEEF one cycle later → source_ready at T+3 with 0xDEADBEEF; prefetch cmd issued at 0x8000_0014.
- Sequential burst of 8 words from 0x8000_0000 with 1-cycle memory → words 2..8 served as hits with source_ready 1 cycle after valid; exactly 9 ICB reads, the last being a prefetch.
- Non-sequential: 0x100 then 0x200 → prefetch of 0x104 completes, the 0x200 request misses, pf buffer reloads with 0x204.
- Demand rsp_err at 0x300 → source_data=0, err_o=1, err_addr_o=0x300. A second error at 0x400 leaves err_addr_o=0x300. err_clr_i clears both. Error on prefetch 0x304 leaves err_o=0.
- flush_i during P_RSP of 0x504, then request 0x504 → the response is discarded and a fresh demand read to 0x504 is issued.
- Request 0xFFFF_FFFC → served, no prefetch issued. rst_n low mid-D_RSP → all outputs 0 at the next edge, FSM in IDLE.

Source files
------------

// File: rtl/mvu_dma_pkg.sv
// Shared types and constants for the MVU DMA source read path.
// Status-word bit positions are shared with the register block.
package mvu_dma_pkg;

    localparam int WORD_BYTES        = 4;
    localparam int STAT_ERR_BIT      = 0;
    localparam int STAT_PF_VALID_BIT = 1;

    typedef enum logic [2:0] {
        SRC_IDLE,
        SRC_D_CMD,
        SRC_D_RSP,
        SRC_P_CMD,
        SRC_P_RSP,
        SRC_ACK
    } src_state_e;

endpackage

// File: rtl/mvu_dma_src_pfbuf.sv
// One-word sequential prefetch buffer for the DMA source ICB master.
// Holds the speculative word, its address, and the in-flight marker.
module mvu_dma_src_pfbuf #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              inv,
    input  logic              start,
    input  logic              rsp_fire,
    input  logic              rsp_err,
    input  logic [ADDR_W-1:0] rsp_addr,
    input  logic [DATA_W-1:0] rsp_data,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              hit,
    output logic [DATA_W-1:0] pf_data
);

    logic [ADDR_W-1:0] pf_addr;
    logic              pf_valid;
    logic              pf_pending;

    // A flush in the same cycle hides the stale word at once
    assign hit = pf_valid && !flush_i && (pf_addr == lookup_addr);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pf_valid   <= 1'b0;
            pf_pending <= 1'b0;
            pf_addr    <= '0;
            pf_data    <= '0;
        end else begin
            if (start) begin
                pf_pending <= !flush_i;
            end else if (flush_i || rsp_fire) begin
                pf_pending <= 1'b0;
            end

            if (flush_i || inv) begin
                pf_valid <= 1'b0;
            end else if (rsp_fire && pf_pending) begin
                pf_valid <= !rsp_err;
                if (!rsp_err) begin
                    pf_addr <= rsp_addr;
                    pf_data <= rsp_data;
                end
            end
        end
    end

endmodule

// File: rtl/mvu_dma_src_icb_master.sv
// DMA source read engine: word requests to single-outstanding ICB reads,
// with an optional one-word sequential prefetch.
module mvu_dma_src_icb_master
    import mvu_dma_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter bit PREFETCH_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   source_address,
    input  logic                source_valid,
    output logic                source_ready,
    output logic [DATA_W-1:0]   source_data,
    input  logic                flush_i,
    output logic                m_icb_cmd_valid,
    input  logic                m_icb_cmd_ready,
    output logic [ADDR_W-1:0]   m_icb_cmd_addr,
    output logic                m_icb_cmd_read,
    output logic [DATA_W-1:0]   m_icb_cmd_wdata,
    output logic [DATA_W/8-1:0] m_icb_cmd_wmask,
    input  logic                m_icb_rsp_valid,
    output logic                m_icb_rsp_ready,
    input  logic                m_icb_rsp_err,
    input  logic [DATA_W-1:0]   m_icb_rsp_rdata,
    output logic                err_o,
    output logic [ADDR_W-1:0]   err_addr_o,
    input  logic                err_clr_i
);

    localparam logic [ADDR_W-1:0] LAST_WORD = {{(ADDR_W-2){1'b1}}, 2'b00};
    localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(WORD_BYTES);

    src_state_e        state, state_nxt;
    logic [ADDR_W-1:0] req_addr;
    logic [ADDR_W-1:0] src_aligned;
    logic              dem_err;
    logic              pf_hit;
    logic [DATA_W-1:0] pf_data;
    logic              d_done, p_done;
    logic              pf_start, pf_inv;
    logic              addr_lsb_unused;

    assign src_aligned     = {source_address[ADDR_W-1:2], 2'b00};
    assign addr_lsb_unused = ^source_address[1:0];

    assign d_done   = (state == SRC_D_RSP) && m_icb_rsp_valid;
    assign p_done   = (state == SRC_P_RSP) && m_icb_rsp_valid;
    assign pf_start = (state == SRC_ACK) && (state_nxt == SRC_P_CMD);
    assign pf_inv   = (state == SRC_IDLE) && source_valid && !pf_hit;

    always_comb begin
        state_nxt = state;
        unique case (state)
            SRC_IDLE:  if (source_valid)
                           state_nxt = pf_hit ? SRC_ACK : SRC_D_CMD;
            SRC_D_CMD: if (m_icb_cmd_ready) state_nxt = SRC_D_RSP;
            // A request withdrawn mid-read is completed on the bus but not acked
            SRC_D_RSP: if (m_icb_rsp_valid)
                           state_nxt = source_valid ? SRC_ACK : SRC_IDLE;
            SRC_ACK:   state_nxt = (PREFETCH_EN && !dem_err &&
                                    req_addr != LAST_WORD) ? SRC_P_CMD : SRC_IDLE;
            SRC_P_CMD: if (m_icb_cmd_ready) state_nxt = SRC_P_RSP;
            SRC_P_RSP: if (m_icb_rsp_valid) state_nxt = SRC_IDLE;
            default:   state_nxt = SRC_IDLE;
        endcase
    end

    assign source_ready    = (state == SRC_ACK);
    assign m_icb_cmd_valid = (state == SRC_D_CMD) || (state == SRC_P_CMD);
    assign m_icb_rsp_ready = (state == SRC_D_RSP) || (state == SRC_P_RSP);
    assign m_icb_cmd_addr  = req_addr;
    assign m_icb_cmd_read  = 1'b1;
    assign m_icb_cmd_wdata = '0;
    assign m_icb_cmd_wmask = '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= SRC_IDLE;
            req_addr    <= '0;
            dem_err     <= 1'b0;
            source_data <= '0;
            err_o       <= 1'b0;
            err_addr_o  <= '0;
        end else begin
            state <= state_nxt;
            if ((state == SRC_IDLE) && source_valid) begin
                req_addr <= src_aligned;
                dem_err  <= 1'b0;
                if (pf_hit) source_data <= pf_data;
            end
            if (d_done) begin
                dem_err <= m_icb_rsp_err;
                if (source_valid)
                    source_data <= m_icb_rsp_err ? '0 : m_icb_rsp_rdata;
            end
            if (pf_start) req_addr <= req_addr + STEP;
            if (d_done && m_icb_rsp_err) begin
                err_o <= 1'b1;
                if (!err_o || err_clr_i) err_addr_o <= req_addr;
            end else if (err_clr_i) begin
                err_o      <= 1'b0;
                err_addr_o <= '0;
            end
        end
    end

    mvu_dma_src_pfbuf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_pfbuf (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush_i),
        .inv         (pf_inv),
        .start       (pf_start),
        .rsp_fire    (p_done),
        .rsp_err     (m_icb_rsp_err),
        .rsp_addr    (req_addr),
        .rsp_data    (m_icb_rsp_rdata),
        .lookup_addr (src_aligned),
        .hit         (pf_hit),
        .pf_data     (pf_data)
    );

endmodule

// File: tb/tb_mvu_dma_src_icb_master.sv
// Scoreboard bench for mvu_dma_src_icb_master with an ICB memory model.
`timescale 1ns/1ps
module tb_mvu_dma_src_icb_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] source_address = '0;
    logic        source_valid = 1'b0;
    logic        source_ready;
    logic [31:0] source_data;
    logic        flush_i = 1'b0;
    logic        m_icb_cmd_valid;
    logic        m_icb_cmd_ready;
    logic [31:0] m_icb_cmd_addr;
    logic        m_icb_cmd_read;
    logic [31:0] m_icb_cmd_wdata;
    logic [3:0]  m_icb_cmd_wmask;
    logic        m_icb_rsp_valid;
    logic        m_icb_rsp_ready;
    logic        m_icb_rsp_err;
    logic [31:0] m_icb_rsp_rdata;
    logic        err_o;
    logic [31:0] err_addr_o;
    logic        err_clr_i = 1'b0;

    always #5 clk = ~clk;

    mvu_dma_src_icb_master dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .source_address  (source_address),
        .source_valid    (source_valid),
        .source_ready    (source_ready),
        .source_data     (source_data),
        .flush_i         (flush_i),
        .m_icb_cmd_valid (m_icb_cmd_valid),
        .m_icb_cmd_ready (m_icb_cmd_ready),
        .m_icb_cmd_addr  (m_icb_cmd_addr),
        .m_icb_cmd_read  (m_icb_cmd_read),
        .m_icb_cmd_wdata (m_icb_cmd_wdata),
        .m_icb_cmd_wmask (m_icb_cmd_wmask),
        .m_icb_rsp_valid (m_icb_rsp_valid),
        .m_icb_rsp_ready (m_icb_rsp_ready),
        .m_icb_rsp_err   (m_icb_rsp_err),
        .m_icb_rsp_rdata (m_icb_rsp_rdata),
        .err_o           (err_o),
        .err_addr_o      (err_addr_o),
        .err_clr_i       (err_clr_i)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
        logic [31:0] eaddr;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] cmd_log[$];
    int          n_checks = 0;
    int          n_pass = 0;
    logic        m_err = 1'b0;
    logic [31:0] m_eaddr = '0;
    bit          rand_mode = 1'b0;
    int          fix_rsp_lat = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h8000_0010) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B1) ^ 32'hC3C3_0F0F;
    endfunction

    // Error words: 0x300, 0x310, ..., 0x400, 0x410, ... (low region only)
    function automatic logic is_err(input logic [31:0] a);
        return (a[31:12] == 20'h0) && (a[11:8] inside {4'h3, 4'h4}) &&
               (a[3:2] == 2'b00);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // ICB memory: decisions made on the falling edge, fire on the next rise
    initial begin
        bit          busy = 0, cmd_fire_q = 0, rsp_fire_q = 0;
        int          cmd_wait = 0, rsp_wait = 0;
        logic [31:0] cur_addr = '0;
        m_icb_cmd_ready = 1'b0;
        m_icb_rsp_valid = 1'b0;
        m_icb_rsp_err   = 1'b0;
        m_icb_rsp_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_icb_cmd_ready = 1'b0;
                m_icb_rsp_valid = 1'b0;
                busy = 0; cmd_fire_q = 0; rsp_fire_q = 0; cmd_wait = 0;
            end else begin
                if (rsp_fire_q) begin
                    busy = 0;
                    m_icb_rsp_valid = 1'b0;
                    cmd_wait = rand_mode ? int'($urandom_range(0, 2)) : 0;
                end
                if (cmd_fire_q) begin
                    busy = 1;
                    m_icb_cmd_ready = 1'b0;
                    rsp_wait = rand_mode ? int'($urandom_range(0, 3)) : fix_rsp_lat;
                end
                cmd_fire_q = 0;
                rsp_fire_q = 0;
                if (busy) begin
                    if (rsp_wait == 0) begin
                        m_icb_rsp_valid = 1'b1;
                        m_icb_rsp_err   = is_err(cur_addr);
                        m_icb_rsp_rdata = mem_word(cur_addr);
                        rsp_fire_q      = m_icb_rsp_ready;
                    end else begin
                        rsp_wait--;
                    end
                end else if (m_icb_cmd_valid) begin
                    if (cmd_wait == 0) begin
                        m_icb_cmd_ready = 1'b1;
                        cmd_fire_q = 1;
                        cur_addr = m_icb_cmd_addr;
                        cmd_log.push_back(cur_addr);
                    end else begin
                        cmd_wait--;
                        m_icb_cmd_ready = 1'b0;
                    end
                end else begin
                    m_icb_cmd_ready = 1'b0;
                end
            end
        end
    end

    // Monitor: every acknowledge is matched against the scoreboard head
    always @(negedge clk) begin
        if (rst_n && source_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_ack", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("source_data", source_data, e.data);
                chk("err_o", {31'b0, err_o}, {31'b0, e.err});
                chk("err_addr_o", err_addr_o, e.eaddr);
            end
        end
    end

    task automatic do_req(input logic [31:0] a, output int lat);
        exp_t e;
        e.addr = a;
        e.data = is_err(a) ? 32'h0 : mem_word(a);
        if (is_err(a)) begin
            if (!m_err) m_eaddr = a;
            m_err = 1'b1;
        end
        e.err   = m_err;
        e.eaddr = m_eaddr;
        exp_q.push_back(e);
        source_address = a | 32'($urandom_range(0, 3));
        source_valid   = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!source_ready && lat < 300);
        chk("ack_seen", {31'b0, source_ready}, 32'd1);
        @(posedge clk);
        #1;
        source_valid = 1'b0;
    endtask

    task automatic wait_quiet();
        int q = 0;
        for (int i = 0; i < 300 && q < 2; i++) begin
            @(negedge clk);
            if (!m_icb_cmd_valid && !m_icb_rsp_ready && !source_ready) q++;
            else q = 0;
        end
        if (q < 2) chk("quiet_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cmds(input int n);
        for (int i = 0; i < 300 && cmd_log.size() < n; i++) @(negedge clk);
        chk("cmd_wait", 32'(cmd_log.size()), 32'(n));
    endtask

    task automatic pulse_clr();
        err_clr_i = 1'b1;
        @(posedge clk);
        #1;
        err_clr_i = 1'b0;
        m_err   = 1'b0;
        m_eaddr = '0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, n0, hits;
        logic [31:0] a;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_source_ready", {31'b0, source_ready}, 32'd0);
        chk("rst_source_data", source_data, 32'd0);
        chk("rst_cmd_valid", {31'b0, m_icb_cmd_valid}, 32'd0);
        chk("rst_cmd_read", {31'b0, m_icb_cmd_read}, 32'd1);
        chk("rst_cmd_addr", m_icb_cmd_addr, 32'd0);
        chk("rst_rsp_ready", {31'b0, m_icb_rsp_ready}, 32'd0);
        chk("rst_err_o", {31'b0, err_o}, 32'd0);
        chk("rst_err_addr", err_addr_o, 32'd0);
        chk("rst_wdata_wmask", {m_icb_cmd_wdata[27:0], m_icb_cmd_wmask}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single miss, then prefetch of the next word
        n0 = cmd_log.size();
        do_req(32'h8000_0010, lat);
        chk("miss_latency", 32'(lat), 32'd4);
        wait_quiet();
        chk("miss_cmd_count", 32'(cmd_log.size() - n0), 32'd2);
        chk("miss_cmd_addr", cmd_log[n0], 32'h8000_0010);
        chk("miss_pf_addr", cmd_log[n0+1], 32'h8000_0014);

        // Sequential burst: first miss, then seven hits
        n0 = cmd_log.size();
        for (int i = 0; i < 8; i++) begin
            do_req(32'h8000_0000 + 32'(4 * i), lat);
            chk("burst_latency", 32'(lat), (i == 0) ? 32'd4 : 32'd2);
            wait_quiet();
        end
        chk("burst_cmd_count", 32'(cmd_log.size() - n0), 32'd9);
        chk("burst_last_cmd", cmd_log[cmd_log.size()-1], 32'h8000_0020);

        // Non-sequential: prefetch reloads on the second miss
        n0 = cmd_log.size();
        do_req(32'h100, lat);
        wait_quiet();
        do_req(32'h200, lat);
        chk("nonseq_miss_latency", 32'(lat), 32'd4);
        wait_quiet();
        chk("nonseq_cmd_count", 32'(cmd_log.size() - n0), 32'd4);
        chk("nonseq_cmd1", cmd_log[n0+1], 32'h104);
        chk("nonseq_cmd3", cmd_log[n0+3], 32'h204);
        do_req(32'h204, lat);
        chk("nonseq_hit_latency", 32'(lat), 32'd2);
        wait_quiet();

        // Demand errors: sticky flag, first address kept, no prefetch
        n0 = cmd_log.size();
        do_req(32'h300, lat);
        wait_quiet();
        chk("err_no_prefetch", 32'(cmd_log.size() - n0), 32'd1);
        do_req(32'h400, lat);
        wait_quiet();
        chk("err2_addr_kept", err_addr_o, 32'h300);
        pulse_clr();
        chk("clr_err_o", {31'b0, err_o}, 32'd0);
        chk("clr_err_addr", err_addr_o, 32'd0);
        // Speculative read of 0x300 fails: flag stays clear, word re-read
        n0 = cmd_log.size();
        do_req(32'h2FC, lat);
        wait_quiet();
        chk("pf_err_cmds", 32'(cmd_log.size() - n0), 32'd2);
        chk("pf_err_no_flag", {31'b0, err_o}, 32'd0);
        do_req(32'h300, lat);
        chk("after_pf_err_latency", 32'(lat), 32'd4);
        wait_quiet();
        pulse_clr();

        // Flush while the prefetch of 0x504 is in flight
        fix_rsp_lat = 5;
        do_req(32'h500, lat);
        n0 = cmd_log.size();
        wait_cmds(n0 + 1);
        @(posedge clk);
        #1;
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        do_req(32'h504, lat);
        wait_quiet();
        hits = 0;
        foreach (cmd_log[i]) if (i >= n0 - 1 && cmd_log[i] == 32'h504) hits++;
        chk("flush_reread_504", 32'(hits), 32'd2);
        fix_rsp_lat = 0;

        // Top word: served, never wraps into a prefetch
        n0 = cmd_log.size();
        do_req(32'hFFFF_FFFC, lat);
        wait_quiet();
        chk("wrap_cmd_count", 32'(cmd_log.size() - n0), 32'd1);

        // Request withdrawn mid-read: read completes, no ack, no prefetch
        fix_rsp_lat = 3;
        n0 = cmd_log.size();
        source_address = 32'h8000_2000;
        source_valid = 1'b1;
        wait_cmds(n0 + 1);
        @(posedge clk);
        #1;
        source_valid = 1'b0;
        wait_quiet();
        chk("withdraw_cmd_count", 32'(cmd_log.size() - n0), 32'd1);

        // Reset in the middle of a demand response wait
        fix_rsp_lat = 6;
        n0 = cmd_log.size();
        source_address = 32'h8000_1000;
        source_valid = 1'b1;
        wait_cmds(n0 + 1);
        @(posedge clk);
        #1;
        chk("pre_rst_in_rsp", {31'b0, m_icb_rsp_ready}, 32'd1);
        rst_n = 1'b0;
        source_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_rsp_ready", {31'b0, m_icb_rsp_ready}, 32'd0);
        chk("mid_rst_cmd_valid", {31'b0, m_icb_cmd_valid}, 32'd0);
        chk("mid_rst_source_ready", {31'b0, source_ready}, 32'd0);
        chk("mid_rst_source_data", source_data, 32'd0);
        chk("mid_rst_err_o", {31'b0, err_o}, 32'd0);
        m_err = 1'b0;
        m_eaddr = '0;
        rst_n = 1'b1;
        fix_rsp_lat = 0;
        @(posedge clk);
        #1;
        do_req(32'h8000_1000, lat);
        chk("post_rst_latency", 32'(lat), 32'd4);
        wait_quiet();

        // Randomized traffic with random memory timing
        rand_mode = 1'b1;
        a = 32'h8000_0000;
        for (int i = 0; i < 300; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 6) a = a + 32'd4;
            else if (r < 8) a = 32'h8000_1000 + ($urandom_range(0, 255) << 2);
            else a = 32'h2C0 + ($urandom_range(0, 79) << 2);
            do_req(a, lat);
            r = int'($urandom_range(0, 7));
            if (r == 0) begin
                wait_quiet();
            end else if (r == 1) begin
                flush_i = 1'b1;
                @(posedge clk);
                #1;
                flush_i = 1'b0;
            end else if (r == 2) begin
                pulse_clr();
                chk("rand_clr_err_o", {31'b0, err_o}, 32'd0);
            end else begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
        end
        wait_quiet();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
